axis_frame_buffer: RTL and testbench



---
 rtl/axis_frame_buffer.sv | 127 ++++++++++++
 tb/tb_axis_frame_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_buffer.sv
// Frame buffer: captures a configured-length AXI-Stream frame, then replays it forward or reversed.
// Optional macro AXIS_FB_LAST_CHECK_EN flags input TLAST misplacement on the sticky err output.
module axis_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              cfg_valid,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_rev,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wr;
    logic [LEN_W-1:0]  cnt;
    logic              rev;
    logic [DATA_W-1:0] mem [DEPTH];

    logic          cfg_ok;
    logic          wr_hs;
    logic          out_hs;
    logic          issue;
    logic [AW-1:0] rd_addr;

    assign cfg_ok  = cfg_valid && (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
    assign wr_hs   = (state == FILL) && S_AXIS_TVALID;
    assign out_hs  = M_AXIS_TVALID && M_AXIS_TREADY;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign issue   = (state == DRAIN) && (cnt != len) && (!M_AXIS_TVALID || M_AXIS_TREADY);
    assign rd_addr = AW'(rev ? (len - cnt - LEN_W'(1)) : cnt);

    assign S_AXIS_TREADY = (state == FILL);
    assign busy          = (state != IDLE);

    // Storage has no reset so an aborted frame leaves contents intact.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_hs)
            mem[wr[AW-1:0]] <= S_AXIS_TDATA;
    end

`ifdef AXIS_FB_LAST_CHECK_EN
    logic err_q;
    assign err = err_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
            err_q <= 1'b0;
        else if (state == IDLE && cfg_ok)
            err_q <= 1'b0;
        else if (wr_hs && (S_AXIS_TLAST != (wr == len - LEN_W'(1))))
            err_q <= 1'b1;
    end
`else
    logic unused_tlast;
    assign unused_tlast = S_AXIS_TLAST;
    assign err          = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state         <= IDLE;
            len           <= '0;
            rev           <= 1'b0;
            wr            <= '0;
            cnt           <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_ok) begin
                        len   <= cfg_len;
                        rev   <= cfg_rev;
                        wr    <= '0;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (wr_hs) begin
                        wr <= wr + LEN_W'(1);
                        if (wr == len - LEN_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= mem[rd_addr];
                        M_AXIS_TLAST  <= (cnt == len - LEN_W'(1));
                        cnt           <= cnt + LEN_W'(1);
                    end else if (out_hs) begin
                        M_AXIS_TVALID <= 1'b0;
                    end
                    if (out_hs && M_AXIS_TLAST) begin
                        M_AXIS_TLAST <= 1'b0;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_buffer.sv
// Scoreboard bench for axis_frame_buffer: expected output words are queued as frames are sent.
module tb_axis_frame_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              S_AXI_ARESETN = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_rev = 1'b0;
    logic              S_AXIS_TVALID = 1'b0;
    logic              S_AXIS_TREADY;
    logic [DATA_W-1:0] S_AXIS_TDATA = '0;
    logic              S_AXIS_TLAST = 1'b0;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY = 1'b0;
    logic [DATA_W-1:0] M_AXIS_TDATA;
    logic              M_AXIS_TLAST;
    logic              busy, done, err;

    axis_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .cfg_valid(cfg_valid), .cfg_len(cfg_len), .cfg_rev(cfg_rev),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DATA_W:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: hold low
    logic last_hs_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [DATA_W-1:0] data_prev = '0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
            default: M_AXIS_TREADY = 1'b0;
        endcase
    end

    // Output monitor: pops the scoreboard on each handshake, checks stall hold and done timing.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (!S_AXI_ARESETN) begin
            last_hs_prev = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (last_hs_prev) begin
                total++;
                if (done !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin
                    bad++;
                    $display("FAIL done_after_last: done=%b tvalid=%b, want done=1 tvalid=0", done, M_AXIS_TVALID);
                end
            end else if (done === 1'b1) begin
                total++;
                bad++;
                $display("FAIL spurious_done: done=1 without preceding last handshake, want 0");
            end
            if (done === 1'b1) done_cnt++;
            if (stall_prev) begin
                total++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== data_prev) begin
                    bad++;
                    $display("FAIL stall_hold: tvalid=%b data=%h, want tvalid=1 data=%h", M_AXIS_TVALID, M_AXIS_TDATA, data_prev);
                end
            end
            if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got last=%b data=%h, want no word", M_AXIS_TLAST, M_AXIS_TDATA);
                end else begin
                    e = exp_q.pop_front();
                    if ({M_AXIS_TLAST, M_AXIS_TDATA} !== e) begin
                        bad++;
                        $display("FAIL out_word: got last=%b data=%h, want last=%b data=%h", M_AXIS_TLAST, M_AXIS_TDATA, e[DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            last_hs_prev = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
            stall_prev   = M_AXIS_TVALID & ~M_AXIS_TREADY;
            data_prev    = M_AXIS_TDATA;
        end
    end

    task automatic do_cfg(input int l, input bit r);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_len   = l[LEN_W-1:0];
        cfg_rev   = r;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Sends n words with TLAST on word last_at and queues the expected replay order.
    task automatic send_frame(input int n, input bit r, input int last_at, input bit rnd, input bit drop_cfg);
        logic [DATA_W-1:0] d[];
        bit ok;
        bit seen;
        int t;
        d = new[n];
        for (int i = 0; i < n; i++) d[i] = rnd ? $urandom : (i + 1) * 32'h11;
        for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, d[r ? n - 1 - k : k]});
        for (int i = 0; i < n; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = d[i];
            S_AXIS_TLAST  = (i == last_at);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 100) begin
                @(negedge clk);
                ok = S_AXIS_TREADY;
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL in_handshake_timeout: word %0d tready=0, want 1", i);
                break;
            end
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        if (drop_cfg) cfg_valid = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (M_AXIS_TVALID === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL drain_latency: tvalid=0 two cycles after last input, want 1");
        end
    endtask

    task automatic wait_frame(input int want);
        int t = 0;
        while (done_cnt < want && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        total++;
        if (done_cnt < want) begin
            bad++;
            $display("FAIL done_timeout: done count=%0d, want %0d", done_cnt, want);
        end
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: left=%0d busy=%b, want left=0 busy=0", exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        S_AXI_ARESETN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (S_AXIS_TREADY !== 1'b0 || M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: tready=%b tvalid=%b tlast=%b, want 0 0 0", S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b err=%b, want 0 0 0", busy, done, err);
        end
        total++;
        if (M_AXIS_TDATA !== '0) begin
            bad++;
            $display("FAIL reset_data: tdata=%h, want 0", M_AXIS_TDATA);
        end
        S_AXI_ARESETN = 1'b1;
    endtask

    task automatic test_frame(input int n, input bit r, input bit rnd);
        int d0 = done_cnt;
        do_cfg(n, r);
        send_frame(n, r, n - 1, rnd, 1'b0);
        wait_frame(d0 + 1);
    endtask

    task automatic test_stall();
        rdy_mode = 1;
        test_frame(DEPTH, 1'b0, 1'b1);
        rdy_mode = 0;
    endtask

    task automatic test_bad_cfg();
        int d0;
        do_cfg(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL cfg_len0: busy=%b, want 0", busy);
        end
        do_cfg(DEPTH + 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL cfg_len65: busy=%b, want 0", busy);
        end
        d0 = done_cnt;
        do_cfg(4, 1'b0);
        cfg_valid = 1'b1;
        cfg_len   = 7'd2;
        cfg_rev   = 1'b1;
        send_frame(4, 1'b0, 3, 1'b1, 1'b1);
        wait_frame(d0 + 1);
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int c = 0;
        do_cfg(8, 1'b0);
        send_frame(8, 1'b0, 7, 1'b1, 1'b0);
        while (done_cnt == d0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        total++;
        if (c > 9) begin
            bad++;
            $display("FAIL back_to_back: %0d cycles to drain 8 words, want <= 9", c);
        end
        wait_frame(d0 + 1);
    endtask

    task automatic test_reset_mid_drain();
        int h0;
        int t = 0;
        int d0;
        rdy_mode = 2;
        do_cfg(4, 1'b0);
        send_frame(4, 1'b0, 3, 1'b0, 1'b0);
        h0 = hs_cnt;
        rdy_mode = 0;
        while (hs_cnt < h0 + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        rdy_mode = 2;
        #1;
        S_AXI_ARESETN = 1'b0;
        @(posedge clk); #1;
        total++;
        if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: tvalid=%b busy=%b, want 0 0", M_AXIS_TVALID, busy);
        end
        total++;
        if (exp_q.size() != 2) begin
            bad++;
            $display("FAIL reset_abort_count: %0d words pending, want 2", exp_q.size());
        end
        exp_q.delete();
        S_AXI_ARESETN = 1'b1;
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (hs_cnt != h0 + 2) begin
            bad++;
            $display("FAIL reset_no_emit: %0d handshakes, want %0d", hs_cnt, h0 + 2);
        end
        d0 = done_cnt;
        do_cfg(2, 1'b0);
        send_frame(2, 1'b0, 1, 1'b1, 1'b0);
        wait_frame(d0 + 1);
    endtask

    task automatic test_last_check();
        int d0 = done_cnt;
        do_cfg(3, 1'b0);
        send_frame(3, 1'b0, 1, 1'b0, 1'b0);
        wait_frame(d0 + 1);
`ifdef AXIS_FB_LAST_CHECK_EN
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: err=%b, want 1", err);
        end
        do_cfg(2, 1'b0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err=%b, want 0", err);
        end
        send_frame(2, 1'b0, 1, 1'b1, 1'b0);
        wait_frame(d0 + 2);
`else
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_tied: err=%b, want 0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame(4, 1'b0, 1'b0);
        test_frame(4, 1'b1, 1'b0);
        test_frame(1, 1'b1, 1'b1);
        test_frame(DEPTH, 1'b1, 1'b1);
        test_stall();
        test_bad_cfg();
        test_back_to_back();
        test_reset_mid_drain();
        test_last_check();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
